hazard_ctrl: RTL

// - Parametrised pipeline hazard controller for the rvga core: per-stage stall, flush and bubble

---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / bubble control for an N-stage in-order pipeline.
// Stage 0 is ifetch (youngest) and stage NUM_STAGES_P-1 is writeback (oldest).
// Per-port FSMs track outstanding imem/dmem requests, drop responses orphaned
// by a flush, and raise a sticky timeout when a port hangs.
// Optional feature macro: HAZARD_PERF_EN (adds stall_cnt_o / flush_cnt_o).
module hazard_ctrl #(
  parameter int unsigned NUM_STAGES_P = 6,
  parameter int unsigned IFETCH_IDX_P = 0,
  parameter int unsigned MEM_IDX_P    = 4,
  parameter int unsigned TIMEOUT_P    = 255,
  parameter int unsigned CNT_WIDTH_P  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    imem_req_v_i,
  input  logic                    imem_resp_v_i,
  input  logic                    dmem_req_v_i,
  input  logic                    dmem_resp_v_i,
  input  logic [NUM_STAGES_P-1:0] br_v_i,
  output logic [NUM_STAGES_P-1:0] stall_v_o,
  output logic [NUM_STAGES_P-1:0] flush_v_o,
  output logic [NUM_STAGES_P-1:0] bubble_v_o,
  output logic                    imem_discard_o,
  output logic                    dmem_discard_o,
  output logic                    timeout_v_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH_P-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH_P-1:0]  flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } port_state_e;

  localparam int unsigned TO_W = (TIMEOUT_P > 0) ? $clog2(TIMEOUT_P + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_P);

  // Reject illegal geometries at elaboration time.
  if (NUM_STAGES_P < 3 || IFETCH_IDX_P >= MEM_IDX_P || MEM_IDX_P >= NUM_STAGES_P ||
      CNT_WIDTH_P == 0) begin : g_bad_params
    $error("hazard_ctrl: illegal parameter combination");
  end

  port_state_e     imem_state_q, imem_state_d;
  port_state_e     dmem_state_q, dmem_state_d;
  logic [TO_W-1:0] imem_to_cnt_q, imem_to_cnt_d;
  logic [TO_W-1:0] dmem_to_cnt_q, dmem_to_cnt_d;
  logic            timeout_q, timeout_d;

  logic                    imem_stall, dmem_stall;
  logic [NUM_STAGES_P-1:0] stall_raw, flush_raw, bubble_raw;

  // Port FSM transition; a response always wins over a same-cycle flush.
  function automatic port_state_e port_next(input port_state_e st, input logic req,
                                            input logic resp, input logic flush);
    port_state_e nxt;
    nxt = st;
    case (st)
      IDLE:    nxt = req ? WAIT : IDLE;
      WAIT: begin
        if (resp)       nxt = req ? WAIT : IDLE;
        else if (flush) nxt = DRAIN;
        else            nxt = WAIT;
      end
      DRAIN:   nxt = resp ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // Timeout counter: runs while a request is outstanding, saturates at the limit.
  function automatic logic [TO_W-1:0] to_next(input port_state_e st, input logic resp,
                                              input logic [TO_W-1:0] cnt);
    logic [TO_W-1:0] nxt;
    if (st == IDLE || resp)  nxt = '0;
    else if (cnt == TO_LIMIT) nxt = cnt;
    else                      nxt = cnt + TO_W'(1);
    return nxt;
  endfunction

  // Combinational stall/flush/bubble masks; zero latency from resp and br_v_i.
  always_comb begin
    imem_stall = ((imem_state_q == WAIT) & ~imem_resp_v_i) | (imem_state_q == DRAIN);
    dmem_stall = ((dmem_state_q == WAIT) & ~dmem_resp_v_i) | (dmem_state_q == DRAIN);
    stall_raw  = '0;
    flush_raw  = '0;
    bubble_raw = '0;
    for (int unsigned s = 0; s < NUM_STAGES_P; s++) begin
      stall_raw[s] = (imem_stall & (IFETCH_IDX_P >= s)) | (dmem_stall & (MEM_IDX_P >= s));
      flush_raw[s] = |(br_v_i >> (s + 1));
    end
    for (int unsigned s = 1; s < NUM_STAGES_P; s++) begin
      bubble_raw[s] = stall_raw[s-1] & ~stall_raw[s] & ~flush_raw[s];
    end
  end

  // Next-state for both port FSMs, their timeout counters and the sticky flag.
  always_comb begin
    imem_state_d  = port_next(imem_state_q, imem_req_v_i, imem_resp_v_i,
                              flush_raw[IFETCH_IDX_P]);
    dmem_state_d  = port_next(dmem_state_q, dmem_req_v_i, dmem_resp_v_i,
                              flush_raw[MEM_IDX_P]);
    imem_to_cnt_d = to_next(imem_state_q, imem_resp_v_i, imem_to_cnt_q);
    dmem_to_cnt_d = to_next(dmem_state_q, dmem_resp_v_i, dmem_to_cnt_q);
    timeout_d     = timeout_q;
    if (TIMEOUT_P != 0 && (imem_to_cnt_d == TO_LIMIT || dmem_to_cnt_d == TO_LIMIT)) begin
      timeout_d = 1'b1;
    end
  end

  // Port FSM and timeout state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imem_state_q  <= IDLE;
      dmem_state_q  <= IDLE;
      imem_to_cnt_q <= '0;
      dmem_to_cnt_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      imem_state_q  <= imem_state_d;
      dmem_state_q  <= dmem_state_d;
      imem_to_cnt_q <= imem_to_cnt_d;
      dmem_to_cnt_q <= dmem_to_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  // Output drive; everything is held low while reset is asserted.
  always_comb begin
    stall_v_o      = rst_i ? '0 : stall_raw;
    flush_v_o      = rst_i ? '0 : flush_raw;
    bubble_v_o     = rst_i ? '0 : bubble_raw;
    imem_discard_o = ~rst_i & (imem_state_q == DRAIN) & imem_resp_v_i;
    dmem_discard_o = ~rst_i & (dmem_state_q == DRAIN) & dmem_resp_v_i;
    timeout_v_o    = ~rst_i & timeout_q;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH_P-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH_P-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: stall cycles and redirect cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (|stall_raw && stall_cnt_q != '1)                    stall_cnt_d = stall_cnt_q + 1'b1;
    if (|br_v_i[NUM_STAGES_P-1:1] && flush_cnt_q != '1)     flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Counter outputs, held low during reset.
  always_comb begin
    stall_cnt_o = rst_i ? '0 : stall_cnt_q;
    flush_cnt_o = rst_i ? '0 : flush_cnt_q;
  end
`endif

endmodule
